// File: rtl/square_wave_period_meter.sv
// Measures the period and high time of an asynchronous square wave in clk cycles.
// A measurement is published on each rising edge that follows an arming edge.
module square_wave_period_meter #(
  parameter int unsigned               PERIOD_WIDTH = 32,
  parameter logic [PERIOD_WIDTH-1:0]   TIMEOUT      = '1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sig_in,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic [PERIOD_WIDTH-1:0] high_time,
  output logic                    valid,
  output logic                    locked
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

  state_t                  state_q;
  logic                    s1_q, s2_q, s3_q;
  logic [PERIOD_WIDTH-1:0] cnt_q, hcnt_q;
  logic [PERIOD_WIDTH-1:0] period_q, high_q;
  logic                    valid_q, locked_q;
  logic                    rise_d;

  // Synchroniser resets high so an input already high at release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    rise_d = s2_q & ~s3_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise_d) begin
            cnt_q   <= ONE;
            hcnt_q  <= ONE;
            state_q <= MEASURE;
          end else begin
            cnt_q  <= '0;
            hcnt_q <= '0;
          end
        end
        MEASURE: begin
          // An edge coinciding with cnt==TIMEOUT still publishes, so cnt never wraps.
          if (rise_d) begin
            period_q <= cnt_q;
            high_q   <= hcnt_q;
            valid_q  <= 1'b1;
            locked_q <= 1'b1;
            cnt_q    <= ONE;
            hcnt_q   <= ONE;
          end else if (cnt_q == TIMEOUT) begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
            period_q <= '0;
            high_q   <= '0;
            cnt_q    <= '0;
            hcnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ONE;
            if (s2_q) begin
              hcnt_q <= hcnt_q + ONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_square_wave_period_meter.sv
// Scoreboard bench for square_wave_period_meter: stimulus pushes expected
// measurements, per-instance monitors pop and compare on each valid pulse.
module tb_square_wave_period_meter;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] h;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig_main = 1'b0, sig_t200 = 1'b0, sig_t100 = 1'b0;
  logic [W-1:0] per_main, hi_main, per_t200, hi_t200, per_t100, hi_t100;
  logic         val_main, lck_main, val_t200, lck_t200, val_t100, lck_t100;

  int checks = 0;
  int errors = 0;
  exp_t q_main[$];
  exp_t q_t200[$];
  exp_t q_t100[$];

  always #5 clk = ~clk;

  square_wave_period_meter #(.PERIOD_WIDTH(W)) dut_main (
    .clk(clk), .rst(rst), .sig_in(sig_main), .period(per_main),
    .high_time(hi_main), .valid(val_main), .locked(lck_main)
  );

  square_wave_period_meter #(.PERIOD_WIDTH(W), .TIMEOUT(16'd200)) dut_t200 (
    .clk(clk), .rst(rst), .sig_in(sig_t200), .period(per_t200),
    .high_time(hi_t200), .valid(val_t200), .locked(lck_t200)
  );

  square_wave_period_meter #(.PERIOD_WIDTH(W), .TIMEOUT(16'd100)) dut_t100 (
    .clk(clk), .rst(rst), .sig_in(sig_t100), .period(per_t100),
    .high_time(hi_t100), .valid(val_t100), .locked(lck_t100)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon(input string tag, input int sel, input logic [W-1:0] p,
                     input logic [W-1:0] h, input logic l);
    exp_t e;
    int   sz;
    sz = (sel == 0) ? q_main.size() : (sel == 1) ? q_t200.size() : q_t100.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_valid: got period=%0d high=%0d expected no valid", tag, p, h);
    end else begin
      if (sel == 0)      e = q_main.pop_front();
      else if (sel == 1) e = q_t200.pop_front();
      else               e = q_t100.pop_front();
      check({tag, "_period"}, 32'(p), 32'(e.p));
      check({tag, "_high_time"}, 32'(h), 32'(e.h));
      check({tag, "_locked_at_valid"}, 32'(l), 32'd1);
    end
  endtask

  always @(negedge clk) if (val_main === 1'b1) mon("main", 0, per_main, hi_main, lck_main);
  always @(negedge clk) if (val_t200 === 1'b1) mon("t200", 1, per_t200, hi_t200, lck_t200);
  always @(negedge clk) if (val_t100 === 1'b1) mon("t100", 2, per_t100, hi_t100, lck_t100);

  task automatic set_sig(input int sel, input logic v);
    case (sel)
      0:       sig_main = v;
      1:       sig_t200 = v;
      default: sig_t100 = v;
    endcase
  endtask

  task automatic push(input int sel, input int ep, input int eh);
    exp_t e;
    e.p = ep[W-1:0];
    e.h = eh[W-1:0];
    case (sel)
      0:       q_main.push_back(e);
      1:       q_t200.push_back(e);
      default: q_t100.push_back(e);
    endcase
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Rising edge, hi cycles high, lo cycles low; the rise publishes the previous period.
  task automatic pulse(input int sel, input int hi, input int lo,
                       input bit exp_v, input int ep, input int eh);
    if (exp_v) push(sel, ep, eh);
    set_sig(sel, 1'b1);
    wait_cyc(hi);
    set_sig(sel, 1'b0);
    wait_cyc(lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_period", 32'(per_main), 0);
    check("reset_high_time", 32'(hi_main), 0);
    check("reset_valid", 32'(val_main), 0);
    check("reset_locked", 32'(lck_main), 0);
    @(posedge clk); #1;

    // Lock-in at 50/50
    pulse(0, 50, 50, 0, 0, 0);
    check("lockin_not_locked_after_arm", 32'(lck_main), 0);
    for (int i = 0; i < 4; i++) pulse(0, 50, 50, 1, 100, 50);
    check("lockin_locked", 32'(lck_main), 1);

    // Duty extremes
    pulse(0, 25, 975, 1, 100, 50);
    pulse(0, 25, 975, 1, 1000, 25);
    pulse(0, 1, 1, 1, 1000, 25);
    for (int i = 0; i < 5; i++) pulse(0, 1, 1, 1, 2, 1);

    // Frequency change 50/50 -> 30/30
    pulse(0, 50, 50, 1, 2, 1);
    pulse(0, 50, 50, 1, 100, 50);
    pulse(0, 30, 30, 1, 100, 50);
    for (int i = 0; i < 3; i++) pulse(0, 30, 30, 1, 60, 30);
    check("freq_hold_period", 32'(per_main), 60);

    // Input held high across reset release
    rst = 1'b1;
    sig_main = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_high_period", 32'(per_main), 0);
    check("rst_high_high_time", 32'(hi_main), 0);
    check("rst_high_locked", 32'(lck_main), 0);
    @(posedge clk); #1;
    wait_cyc(20);
    sig_main = 1'b0;
    wait_cyc(30);
    check("rst_high_no_lock", 32'(lck_main), 0);
    pulse(0, 50, 50, 0, 0, 0);
    pulse(0, 50, 50, 1, 100, 50);
    pulse(0, 50, 50, 1, 100, 50);

    // One-cycle reset mid-period while locked
    push(0, 100, 50);
    sig_main = 1'b1;
    wait_cyc(20);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_period", 32'(per_main), 0);
    check("midrst_high_time", 32'(hi_main), 0);
    check("midrst_valid", 32'(val_main), 0);
    check("midrst_locked", 32'(lck_main), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    wait_cyc(28);
    sig_main = 1'b0;
    wait_cyc(50);
    check("midrst_still_unlocked", 32'(lck_main), 0);
    pulse(0, 50, 50, 0, 0, 0);
    pulse(0, 50, 50, 1, 100, 50);
    pulse(0, 50, 50, 1, 100, 50);

    // Timeout with TIMEOUT=200: lock drops exactly 200 cycles after the last detected edge
    pulse(1, 50, 50, 0, 0, 0);
    pulse(1, 50, 50, 1, 100, 50);
    push(1, 100, 50);
    sig_t200 = 1'b1;
    wait_cyc(50);
    sig_t200 = 1'b0;
    repeat (152) @(posedge clk);
    @(negedge clk);
    check("t200_locked_before_timeout", 32'(lck_t200), 1);
    check("t200_period_before_timeout", 32'(per_t200), 100);
    @(posedge clk);
    @(negedge clk);
    check("t200_locked_after_timeout", 32'(lck_t200), 0);
    check("t200_period_after_timeout", 32'(per_t200), 0);
    check("t200_high_after_timeout", 32'(hi_t200), 0);
    @(posedge clk); #1;
    wait_cyc(20);
    pulse(1, 50, 50, 0, 0, 0);
    check("t200_rearm_not_locked", 32'(lck_t200), 0);
    pulse(1, 50, 50, 1, 100, 50);
    pulse(1, 50, 50, 1, 100, 50);

    // Edge coinciding with cnt==TIMEOUT (TIMEOUT=100, period 100)
    pulse(2, 50, 50, 0, 0, 0);
    for (int i = 0; i < 3; i++) pulse(2, 50, 50, 1, 100, 50);
    check("t100_locked_kept", 32'(lck_t100), 1);
    check("t100_period_held", 32'(per_t100), 100);

    wait_cyc(10);
    check("main_queue_drained", q_main.size(), 0);
    check("t200_queue_drained", q_t200.size(), 0);
    check("t100_queue_drained", q_t100.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
